arm_mc_controller: RTL
======================

# arm_mc_controller

Multicycle control unit for the ARM-subset processor, successor to the single-cycle controller. It sequences each instruction through a state machine and owns the NZCV flag register and condition evaluation. It adds memory wait-state handling and a retired-instruction counter, and is parametrised for optional CMP support. It sits beside the multicycle datapath, which uses one shared instruction/data memory port, and drives every datapath select and enable.

## Interface
- `WAIT_EN`, 1: 1 = honour `mem_ready`; 0 = memory is treated as always ready.
- `CMP_EN`, 1: 1 = cmd 1010 (CMP) sets flags with no register write; 0 = cmd 1010 is undefined.
- `INSTRET_W`, 32: width of the retired-instruction counter.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low. Low = in reset.
- `Instr`, in, 20: instruction bits [31:12], read from the datapath's instruction register.
- `ALUFlags`, in, 4: [3]=Z, [2]=N, [1]=C, [0]=V, from the ALU.
- `mem_ready`, in, 1: memory access completes this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, out, 1 each: write enables.
- `AdrSrc`, `ALUSrcA`, out, 1 each: select 0 = PC / register, 1 = result / PC.
- `ALUSrcB`, `ResultSrc`, `RegSrc`, `ImmSrc`, out, 2 each: datapath selects.
- `ALUControl`, out, 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `instret`, out, `INSTRET_W`: count of retired instructions; wraps.
- `state`, out, 4: current state, for debug.

## Operation
- **States and transitions:**
  - FETCH -> DECODE on ready.
  - DECODE -> MEMADR (op=01), EXECR (op=00, I=0), EXECI (op=00, I=1), BRANCH (op=10), or UNDEF (anything else).
  - MEMADR -> MEMRD (L=1) or MEMWR (L=0).
  - MEMRD -> MEMWB on ready.
  - MEMWR -> FETCH on ready.
  - EXECR / EXECI -> ALUWB.
  - ALUWB, MEMWB, BRANCH -> FETCH.
  - UNDEF -> FETCH, with no writes.
- **"Ready"** means `mem_ready`=1 or `WAIT_EN`=0. FETCH, MEMRD and MEMWR hold until ready.
- **Per-state outputs** (any output not listed is 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. IRWrite and PCWrite assert only on the ready cycle.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite gated by CondEx.
  - MEMWR: AdrSrc=1. MemWrite = CondEx, held every cycle until ready; the memory must tolerate repeated writes.
  - EXECR: ALUSrcB=00, decoded ALUControl. EXECI: ALUSrcB=01, decoded ALUControl.
  - ALUWB: ResultSrc=00, RegWrite = CondEx & ~NoWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ADD, PCWrite = CondEx.
- **Data-processing decode (cmd):**
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP is SUB with NoWrite=1 and flags always written. When `CMP_EN`=0, 1010 decodes as UNDEF.
  - Any other cmd goes to UNDEF.
- **Flag writes:**
  - FlagWrite[1] updates N,Z; FlagWrite[0] updates C,V.
  - Data-processing with S=1 writes N,Z. ADD, SUB and CMP also write C,V.
  - Flags are written only in EXECR/EXECI, and only when CondEx=1.
- **Condition codes:** CondEx is evaluated on `Instr`[31:28] against the *stored* flags, using the standard ARM table (0000 EQ … 1110 AL). 1111 evaluates to 0.
- **Selects:**
  - ImmSrc = op.
  - RegSrc[0] = (op=10); RegSrc[1] = (op=01 & L=0).
- **`instret`** increments by 1 on every transition into FETCH from ALUWB, MEMWB, MEMWR or BRANCH, including when CondEx=0. UNDEF does not count.

## Timing
- **Reset (asynchronous, `reset` low):**
  - state=FETCH, flags=0000, `instret`=0.
  - All write enables are forced 0 while `reset` is low. Selects show the FETCH values.
- **First activity:** the first rising edge after `reset` goes high may fetch, and IRWrite/PCWrite may assert in that cycle.
- **Zero-wait latency:** B 3 cycles; data-processing 4; STR 4; LDR 5. Each wait cycle adds 1.
- **Flag timing:** flags update at the end of the EXEC cycle. The next instruction's CondEx sees the new values.
- **Reset mid-instruction:** the in-flight instruction is abandoned and no partial writes occur after the reset edge.
- **`instret` wrap:** all-ones + 1 = 0, with no sticky bit.

## Structure
- Package `arm_pkg` holds:
  - the state enum (FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNDEF=10);
  - the ALUControl and cmd constants;
  - the flag bit indices.
- Sub-module `arm_cond_unit` holds the flag register, the condition-code table and the CondEx output.

## Test plan
- Reset low mid-LDR in MEMRD -> state=0, all enables 0, `instret`=0. Release -> IRWrite=1 on the first cycle.
- ADD R1,R2,#5 (0xE2821005) with zero wait -> states 0,1,7,8,0. RegWrite=1 only in ALUWB. `instret` +1.
- LDR with `mem_ready` low for 3 cycles in MEMRD -> state holds at 3 for 3 cycles. Total latency 8 cycles.
- CMP R0,R0, then BEQ -> Z=1, no RegWrite. BRANCH PCWrite=1. With R0≠R1 compared first, BRANCH PCWrite=0.
- `CMP_EN`=0 with cmd 1010 -> UNDEF, no writes, `instret` unchanged.
- `INSTRET_W`=4, run 17 instructions -> `instret`=1.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the multicycle ARM-subset control unit.
// Holds the controller state encoding, ALUControl codes, data-processing
// cmd encodings, instruction op classes and NZCV flag bit positions
// (ALUFlags ordering: [3]=Z, [2]=N, [1]=C, [0]=V).
package arm_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        UNDEF  = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register and ARM condition-code evaluation.
// Ports:
//   i_clk, i_rst_n    : clock, asynchronous active-low reset (flags clear to 0)
//   i_cond            : condition field Instr[31:28]
//   i_alu_flags       : {Z,N,C,V} from the ALU
//   i_flag_write      : [1] loads N,Z; [0] loads C,V (already gated by caller)
//   o_cond_ex         : condition passes against the stored flags
module arm_cond_unit
    import arm_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_write,
    output logic       o_cond_ex
);

    logic [3:0] r_flags;
    logic       w_z, w_n, w_c, w_v;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= 4'b0000;
        end else begin
            if (i_flag_write[1]) begin
                r_flags[FLAG_Z] <= i_alu_flags[FLAG_Z];
                r_flags[FLAG_N] <= i_alu_flags[FLAG_N];
            end
            if (i_flag_write[0]) begin
                r_flags[FLAG_C] <= i_alu_flags[FLAG_C];
                r_flags[FLAG_V] <= i_alu_flags[FLAG_V];
            end
        end
    end

    assign w_z = r_flags[FLAG_Z];
    assign w_n = r_flags[FLAG_N];
    assign w_c = r_flags[FLAG_C];
    assign w_v = r_flags[FLAG_V];

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            4'b0000: o_cond_ex = w_z;
            4'b0001: o_cond_ex = ~w_z;
            4'b0010: o_cond_ex = w_c;
            4'b0011: o_cond_ex = ~w_c;
            4'b0100: o_cond_ex = w_n;
            4'b0101: o_cond_ex = ~w_n;
            4'b0110: o_cond_ex = w_v;
            4'b0111: o_cond_ex = ~w_v;
            4'b1000: o_cond_ex = w_c & ~w_z;
            4'b1001: o_cond_ex = ~w_c | w_z;
            4'b1010: o_cond_ex = ~(w_n ^ w_v);
            4'b1011: o_cond_ex = w_n ^ w_v;
            4'b1100: o_cond_ex = ~w_z & ~(w_n ^ w_v);
            4'b1101: o_cond_ex = w_z | (w_n ^ w_v);
            4'b1110: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;  // 1111 never executes
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle control unit for the ARM-subset processor. Sequences each
// instruction through the FSM, drives all datapath selects/enables, owns
// the NZCV flags (via arm_cond_unit) and counts retired instructions.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   Instr[19:0]         : instruction bits [31:12]
//   ALUFlags[3:0]       : {Z,N,C,V} from the ALU
//   mem_ready           : memory access completes this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite : write enables (0 while in reset)
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ImmSrc : datapath selects
//   ALUControl          : 00 ADD, 01 SUB, 10 AND, 11 ORR
//   instret             : retired-instruction count, wraps
//   state               : current FSM state for debug
module arm_mc_controller
    import arm_pkg::*;
#(
    parameter bit WAIT_EN   = 1'b1,
    parameter bit CMP_EN    = 1'b1,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           ALUControl,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state
);

    state_t                 r_state, w_next;
    logic [INSTRET_W-1:0]   r_instret;
    logic [1:0]             w_op;
    logic [3:0]             w_cmd;
    logic                   w_i, w_sl, w_ready, w_cond_ex;
    logic                   w_cmd_ok, w_is_cmp, w_arith;
    logic [1:0]             w_alu_ctl, w_flag_raw, w_flag_write;
    logic                   w_flag_en, w_retire;
    logic                   w_pc_we, w_ir_we, w_reg_we, w_mem_we;
    logic                   w_unused_instr;

    assign w_op  = Instr[15:14];
    assign w_i   = Instr[13];
    assign w_cmd = Instr[12:9];
    assign w_sl  = Instr[8];     // S bit for data-processing, L bit for memory
    assign w_unused_instr = ^Instr[7:0];

    assign w_ready = mem_ready | ~WAIT_EN;

    always_comb begin
        w_cmd_ok  = 1'b1;
        w_is_cmp  = 1'b0;
        w_arith   = 1'b0;
        w_alu_ctl = ALU_ADD;
        case (w_cmd)
            CMD_ADD: begin w_alu_ctl = ALU_ADD; w_arith = 1'b1; end
            CMD_SUB: begin w_alu_ctl = ALU_SUB; w_arith = 1'b1; end
            CMD_AND: w_alu_ctl = ALU_AND;
            CMD_ORR: w_alu_ctl = ALU_ORR;
            CMD_CMP: begin
                w_cmd_ok  = CMP_EN;
                w_alu_ctl = ALU_SUB;
                w_is_cmp  = 1'b1;
                w_arith   = 1'b1;
            end
            default: w_cmd_ok = 1'b0;
        endcase
    end

    // CMP writes all flags regardless of S; logic ops only touch N,Z.
    assign w_flag_raw[1] = w_sl | w_is_cmp;
    assign w_flag_raw[0] = w_arith & (w_sl | w_is_cmp);
    assign w_flag_write  = w_flag_en ? (w_flag_raw & {2{w_cond_ex}}) : 2'b00;

    arm_cond_unit u_cond (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .i_cond       (Instr[19:16]),
        .i_alu_flags  (ALUFlags),
        .i_flag_write (w_flag_write),
        .o_cond_ex    (w_cond_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_reg_we   = 1'b0;
        w_mem_we   = 1'b0;
        w_flag_en  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        case (r_state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (w_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = DECODE;
                end
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    OP_MEM:  w_next = MEMADR;
                    OP_DP:   w_next = !w_cmd_ok ? UNDEF : (w_i ? EXECI : EXECR);
                    OP_BR:   w_next = BRANCH;
                    default: w_next = UNDEF;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = w_sl ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (w_ready) w_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                w_reg_we  = w_cond_ex;
                w_next    = FETCH;
            end
            MEMWR: begin
                // Write strobe is held through wait states.
                AdrSrc   = 1'b1;
                w_mem_we = w_cond_ex;
                if (w_ready) w_next = FETCH;
            end
            EXECR: begin
                ALUControl = w_alu_ctl;
                w_flag_en  = 1'b1;
                w_next     = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_ctl;
                w_flag_en  = 1'b1;
                w_next     = ALUWB;
            end
            ALUWB: begin
                w_reg_we = w_cond_ex & ~w_is_cmp;
                w_next   = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pc_we   = w_cond_ex;
                w_next    = FETCH;
            end
            UNDEF:   w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    // Enables are combinational from state, so gate them with the reset pin
    // to keep them low for the whole time reset is asserted.
    assign PCWrite  = w_pc_we  & reset;
    assign IRWrite  = w_ir_we  & reset;
    assign RegWrite = w_reg_we & reset;
    assign MemWrite = w_mem_we & reset;

    assign RegSrc = {(w_op == OP_MEM) & ~w_sl, (w_op == OP_BR)};
    assign ImmSrc = w_op;

    assign w_retire = (w_next == FETCH) &&
                      (r_state inside {ALUWB, MEMWB, MEMWR, BRANCH});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
    end

    assign instret = r_instret;
    assign state   = r_state;

endmodule
